// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the read cache miss-fill logic.
//   - read state machine encodings observed by the fill engine
//   - fill FSM state encoding
//   - default geometry and derived-width helper functions
package cache_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int LINE_WORDS_DEF = 4;
  localparam int INDEX_W_DEF    = 6;

  localparam logic [1:0] READ_IDLE  = 2'b00;
  localparam logic [1:0] READ_HIT   = 2'b01;
  localparam logic [1:0] READ_STALL = 2'b10;

  typedef enum logic [2:0] {
    F_IDLE   = 3'd0,
    F_REQ    = 3'd1,
    F_BURST  = 3'd2,
    F_COMMIT = 3'd3,
    F_DONE   = 3'd4
  } fill_state_t;

  // Bits selecting a word within a line.
  function automatic int word_sel_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Bits selecting a byte within a word.
  function automatic int byte_sel_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Bits selecting a byte within a line.
  function automatic int offset_w(input int line_words, input int data_w);
    return word_sel_w(line_words) + byte_sel_w(data_w);
  endfunction

  function automatic int tag_w(input int addr_w, input int index_w,
                               input int line_words, input int data_w);
    return addr_w - index_w - offset_w(line_words, data_w);
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: bundle of every signal between the fill engine and the
// read state machine, memory arbiter, data array and tag array.
//   slave  modport: the fill engine (cache_fill_ctrl)
//   master modport: the surrounding cache / memory side
// Signals:
//   read_state, miss_addr                 : read state machine -> fill
//   mem_req, mem_addr / mem_gnt           : burst request / grant
//   mem_rvalid, mem_rdata                 : read beats
//   fill_we, fill_index, fill_word, fill_data : data array write
//   tag_we, tag_index, tag_value          : tag array write (valid implied)
//   mem_done                              : fill complete pulse
interface cache_fill_ctrl_if #(
  parameter int ADDR_W     = cache_pkg::ADDR_W_DEF,
  parameter int DATA_W     = cache_pkg::DATA_W_DEF,
  parameter int LINE_WORDS = cache_pkg::LINE_WORDS_DEF,
  parameter int INDEX_W    = cache_pkg::INDEX_W_DEF
) ();
  import cache_pkg::*;

  localparam int WORD_SEL_W = word_sel_w(LINE_WORDS);
  localparam int TAG_W      = tag_w(ADDR_W, INDEX_W, LINE_WORDS, DATA_W);

  logic [1:0]            read_state;
  logic [ADDR_W-1:0]     miss_addr;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  fill_we;
  logic [INDEX_W-1:0]    fill_index;
  logic [WORD_SEL_W-1:0] fill_word;
  logic [DATA_W-1:0]     fill_data;
  logic                  tag_we;
  logic [INDEX_W-1:0]    tag_index;
  logic [TAG_W-1:0]      tag_value;
  logic                  mem_done;

  modport slave (
    input  read_state, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, fill_we, fill_index, fill_word, fill_data,
           tag_we, tag_index, tag_value, mem_done
  );

  modport master (
    output read_state, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr, fill_we, fill_index, fill_word, fill_data,
           tag_we, tag_index, tag_value, mem_done
  );

endinterface

// File: rtl/fill_beat_counter.sv
// fill_beat_counter: counts burst beats within one line fill.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : clear count to 0 (start of a fill)
//   i_inc     : advance count by one beat
//   i_start   : word the burst starts at
//   o_offset  : word being written, i_start + count, wrapping within the line
//   o_last    : current count is the final beat of the line
module fill_beat_counter #(
  parameter int WORD_SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_inc,
  input  logic [WORD_SEL_W-1:0] i_start,
  output logic [WORD_SEL_W-1:0] o_offset,
  output logic                  o_last
);

  logic [WORD_SEL_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WORD_SEL_W'(1);
    end
  end

  // Sum is truncated to WORD_SEL_W bits so the offset wraps inside the line.
  assign o_offset = i_start + r_count;
  assign o_last   = (r_count == {WORD_SEL_W{1'b1}});

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-fill engine for the rasterizer read cache.
// While the read state machine stalls, fetches the missing line as a memory
// burst, writes every beat into the data array, then writes the tag and
// pulses mem_done so the read side re-evaluates hit.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : cache_fill_ctrl_if.slave (read state, memory, data/tag writes)
// Build option:
//   CRITICAL_WORD_FIRST_EN : burst starts at the missed word and wraps;
//                            mem_addr keeps the word-select bits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// F_IDLE   | waiting for read_state == stall; latches the miss address
// F_REQ    | mem_req held with stable mem_addr until mem_gnt
// F_BURST  | one data array write per mem_rvalid beat
// F_COMMIT | tag/valid written for the filled set
// F_DONE   | mem_done pulse, back to F_IDLE
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int INDEX_W    = INDEX_W_DEF
) (
  input logic              clk,
  input logic              rst,
  cache_fill_ctrl_if.slave bus
);

  localparam int WORD_SEL_W = word_sel_w(LINE_WORDS);
  localparam int BYTE_W     = byte_sel_w(DATA_W);
  localparam int OFFSET_W   = offset_w(LINE_WORDS, DATA_W);
  localparam int TAG_W      = tag_w(ADDR_W, INDEX_W, LINE_WORDS, DATA_W);

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << BYTE_W;
`else
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFFSET_W;
`endif

  fill_state_t           r_state;
  fill_state_t           w_state_nxt;

  logic [TAG_W-1:0]      r_tag;
  logic [INDEX_W-1:0]    r_index;
  logic [WORD_SEL_W-1:0] r_start;
  logic [ADDR_W-1:0]     r_mem_addr;

  logic                  w_latch;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_cnt_last;
  logic [WORD_SEL_W-1:0] w_word;
  logic [WORD_SEL_W-1:0] w_start_nxt;

  logic                  w_mem_req;
  logic                  w_fill_we;
  logic                  w_tag_we;
  logic                  w_mem_done;

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_start_nxt = bus.miss_addr[BYTE_W +: WORD_SEL_W];
`else
  assign w_start_nxt = '0;
`endif

  fill_beat_counter #(
    .WORD_SEL_W (WORD_SEL_W)
  ) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .i_start  (r_start),
    .o_offset (w_word),
    .o_last   (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= F_IDLE;
      r_tag      <= '0;
      r_index    <= '0;
      r_start    <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_tag      <= bus.miss_addr[ADDR_W-1 -: TAG_W];
        r_index    <= bus.miss_addr[OFFSET_W +: INDEX_W];
        r_start    <= w_start_nxt;
        r_mem_addr <= bus.miss_addr & ADDR_MASK;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_mem_req   = 1'b0;
    w_fill_we   = 1'b0;
    w_tag_we    = 1'b0;
    w_mem_done  = 1'b0;
    case (r_state)
      F_IDLE: begin
        if (bus.read_state == READ_STALL) begin
          w_latch     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = F_REQ;
        end
      end
      F_REQ: begin
        w_mem_req = 1'b1;
        if (bus.mem_gnt) begin
          w_state_nxt = F_BURST;
        end
      end
      F_BURST: begin
        if (bus.mem_rvalid) begin
          w_fill_we = 1'b1;
          w_cnt_inc = 1'b1;
          if (w_cnt_last) begin
            w_state_nxt = F_COMMIT;
          end
        end
      end
      F_COMMIT: begin
        w_tag_we    = 1'b1;
        w_state_nxt = F_DONE;
      end
      F_DONE: begin
        w_mem_done  = 1'b1;
        w_state_nxt = F_IDLE;
      end
      default: begin
        w_state_nxt = F_IDLE;
      end
    endcase
  end

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.fill_we    = w_fill_we;
  assign bus.fill_index = r_index;
  assign bus.fill_word  = w_word;
  // Gated so the data array bus stays quiet outside real beats.
  assign bus.fill_data  = w_fill_we ? bus.mem_rdata : '0;
  assign bus.tag_we     = w_tag_we;
  assign bus.tag_index  = r_index;
  assign bus.tag_value  = r_tag;
  assign bus.mem_done   = w_mem_done;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;
  import cache_pkg::*;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  // 0x1234: index = addr[9:4] = 0x23, tag = addr >> 10 = 0x4, word = 1
  localparam logic [31:0] A1234  = 32'h0000_1234;
  localparam int          S1234  = CWF ? 1 : 0;
  localparam logic [31:0] M1234  = CWF ? 32'h0000_1234 : 32'h0000_1230;
  // 0xABCC: index = 0x3C, tag = 0x2A, word = 3
  localparam logic [31:0] AABCC  = 32'h0000_ABCC;
  localparam int          SABCC  = CWF ? 3 : 0;
  localparam logic [31:0] MABCC  = CWF ? 32'h0000_ABCC : 32'h0000_ABC0;
  // 0x1238: index = 0x23, tag = 0x4, word = 2
  localparam logic [31:0] A1238  = 32'h0000_1238;
  localparam int          S1238  = CWF ? 2 : 0;
  localparam logic [31:0] M1238  = CWF ? 32'h0000_1238 : 32'h0000_1230;
  localparam logic [31:0] BEAT_BASE = 32'hB0B0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_ctrl_if bus ();

  cache_fill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.read_state = READ_IDLE;
    bus.miss_addr  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".mem_req"},    bus.mem_req,    0);
    chk({tag, ".mem_addr"},   bus.mem_addr,   0);
    chk({tag, ".fill_we"},    bus.fill_we,    0);
    chk({tag, ".fill_index"}, bus.fill_index, 0);
    chk({tag, ".fill_word"},  bus.fill_word,  0);
    chk({tag, ".fill_data"},  bus.fill_data,  0);
    chk({tag, ".tag_we"},     bus.tag_we,     0);
    chk({tag, ".tag_index"},  bus.tag_index,  0);
    chk({tag, ".tag_value"},  bus.tag_value,  0);
    chk({tag, ".mem_done"},   bus.mem_done,   0);
  endtask

  typedef struct {
    logic [1:0]  rs;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [1:0]  e_word;
    logic        e_tag_we;
    logic        e_done;
    logic [31:0] e_addr;
    logic [5:0]  e_idx;
    logic [21:0] e_tag;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rs, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic e_req, input logic e_we,
                              input int e_word, input logic e_tag_we, input logic e_done,
                              input logic [31:0] e_addr, input logic [5:0] e_idx,
                              input logic [21:0] e_tag);
    vec_t v;
    v.rs = rs; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_word = 2'(e_word % 4);
    v.e_tag_we = e_tag_we; v.e_done = e_done;
    v.e_addr = e_addr; v.e_idx = e_idx; v.e_tag = e_tag;
    return v;
  endfunction

  // results of run_fill
  int          f_we_cnt, f_tag_cnt, f_done_cnt, f_req_cycles;
  int          f_tag_cyc, f_done_cyc;
  int          f_words[$];
  logic [31:0] f_datas[$];
  logic [31:0] f_addr;
  bit          f_addr_stable;
  logic [5:0]  f_tag_idx;
  logic [21:0] f_tag_val;
  logic        f_post_req[2];

  // Stall in cycle 0, then a simple memory model: grant after gnt_delay
  // request cycles, then 4 beats with 'gap' idle cycles between them.
  task automatic run_fill(input logic [31:0] addr, input int gnt_delay, input int gap,
                          input bit hold_stall, input int max_cyc);
    int  req_cnt = 0;
    int  beats   = 0;
    int  gap_cnt = 0;
    bit  granted = 1'b0;
    bit  req_seen = 1'b0;
    f_we_cnt = 0; f_tag_cnt = 0; f_done_cnt = 0; f_req_cycles = 0;
    f_tag_cyc = -1; f_done_cyc = -1;
    f_words.delete(); f_datas.delete();
    f_addr = '0; f_addr_stable = 1'b1; f_tag_idx = '0; f_tag_val = '0;
    f_post_req[0] = 1'bx; f_post_req[1] = 1'bx;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(posedge clk); #1;
      bus.read_state = (cyc == 0 || hold_stall) ? READ_STALL : READ_IDLE;
      bus.miss_addr  = addr;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      if (granted && beats < 4) begin
        if (gap_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = BEAT_BASE + 32'(beats);
          beats++;
          gap_cnt = gap;
        end else begin
          gap_cnt--;
        end
      end
      if (!granted && bus.mem_req) begin
        if (req_cnt == gnt_delay) begin
          bus.mem_gnt = 1'b1;
          granted = 1'b1;
        end
        req_cnt++;
      end
      @(negedge clk);
      if (f_done_cyc >= 0) begin
        f_post_req[cyc - f_done_cyc - 1] = bus.mem_req;
        if (cyc == f_done_cyc + 2) break;
        continue;
      end
      if (bus.mem_req) begin
        f_req_cycles++;
        if (!req_seen) f_addr = bus.mem_addr;
        else if (bus.mem_addr !== f_addr) f_addr_stable = 1'b0;
        req_seen = 1'b1;
      end
      if (bus.fill_we) begin
        f_we_cnt++;
        f_words.push_back(int'(bus.fill_word));
        f_datas.push_back(bus.fill_data);
      end
      if (bus.tag_we) begin
        f_tag_cnt++;
        f_tag_cyc = cyc;
        f_tag_idx = bus.tag_index;
        f_tag_val = bus.tag_value;
      end
      if (bus.mem_done) begin
        f_done_cnt++;
        f_done_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic check_beats(input string tag, input int start);
    chk({tag, ".we_cnt"}, f_we_cnt, 4);
    for (int k = 0; k < 4 && k < f_words.size(); k++) begin
      chk($sformatf("%s.word%0d", tag, k), f_words[k], (start + k) % 4);
      chk($sformatf("%s.data%0d", tag, k), f_datas[k], BEAT_BASE + 32'(k));
    end
  endtask

  vec_t vecs[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    // Stray beats in idle, then a single back-to-back fill of 0x1234.
    // Stall at vector 2, mem_done at vector 9: 8 cycles inclusive.
    vecs[0]  = mk(READ_IDLE,  0, 1, 32'hDEAD_0000, 0, 0, 0, 0, 0, 32'h0, 6'h00, 22'h0);
    vecs[1]  = mk(READ_HIT,   0, 1, 32'hDEAD_0001, 0, 0, 0, 0, 0, 32'h0, 6'h00, 22'h0);
    vecs[2]  = mk(READ_STALL, 0, 1, 32'hDEAD_0002, 0, 0, 0, 0, 0, 32'h0, 6'h00, 22'h0);
    vecs[3]  = mk(READ_STALL, 1, 0, 32'h0,         1, 0, 0, 0, 0, M1234, 6'h23, 22'h4);
    vecs[4]  = mk(READ_STALL, 0, 1, 32'hA000_000A, 0, 1, S1234 + 0, 0, 0, M1234, 6'h23, 22'h4);
    vecs[5]  = mk(READ_STALL, 0, 1, 32'hB000_000B, 0, 1, S1234 + 1, 0, 0, M1234, 6'h23, 22'h4);
    vecs[6]  = mk(READ_STALL, 0, 1, 32'hC000_000C, 0, 1, S1234 + 2, 0, 0, M1234, 6'h23, 22'h4);
    vecs[7]  = mk(READ_STALL, 0, 1, 32'hD000_000D, 0, 1, S1234 + 3, 0, 0, M1234, 6'h23, 22'h4);
    vecs[8]  = mk(READ_IDLE,  0, 1, 32'hEEEE_0000, 0, 0, 0, 1, 0, M1234, 6'h23, 22'h4);
    vecs[9]  = mk(READ_IDLE,  0, 0, 32'h0,         0, 0, 0, 0, 1, M1234, 6'h23, 22'h4);
    vecs[10] = mk(READ_IDLE,  0, 1, 32'hEEEE_0001, 0, 0, 0, 0, 0, M1234, 6'h23, 22'h4);

    do_reset();
    @(negedge clk);
    check_zero("reset");

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      bus.read_state = vecs[i].rs;
      bus.miss_addr  = A1234;
      bus.mem_gnt    = vecs[i].gnt;
      bus.mem_rvalid = vecs[i].rv;
      bus.mem_rdata  = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d.mem_req", i),   bus.mem_req,   vecs[i].e_req);
      chk($sformatf("v%0d.fill_we", i),   bus.fill_we,   vecs[i].e_we);
      chk($sformatf("v%0d.fill_data", i), bus.fill_data, vecs[i].e_we ? vecs[i].rdata : 32'h0);
      if (vecs[i].e_we)
        chk($sformatf("v%0d.fill_word", i), bus.fill_word, vecs[i].e_word);
      chk($sformatf("v%0d.tag_we", i),     bus.tag_we,     vecs[i].e_tag_we);
      chk($sformatf("v%0d.mem_done", i),   bus.mem_done,   vecs[i].e_done);
      chk($sformatf("v%0d.mem_addr", i),   bus.mem_addr,   vecs[i].e_addr);
      chk($sformatf("v%0d.fill_index", i), bus.fill_index, vecs[i].e_idx);
      chk($sformatf("v%0d.tag_index", i),  bus.tag_index,  vecs[i].e_idx);
      chk($sformatf("v%0d.tag_value", i),  bus.tag_value,  vecs[i].e_tag);
    end
    idle_inputs();

    // Delayed grant (5 extra request cycles), one idle cycle between beats,
    // read_state drops after the first cycle and must not disturb the fill.
    do_reset();
    run_fill(AABCC, 5, 1, 1'b0, 60);
    chk("gap.req_cycles",  f_req_cycles, 6);
    chk("gap.addr",        f_addr, MABCC);
    chk("gap.addr_stable", f_addr_stable, 1);
    check_beats("gap", SABCC);
    chk("gap.tag_cnt",  f_tag_cnt, 1);
    chk("gap.tag_idx",  f_tag_idx, 6'h3C);
    chk("gap.tag_val",  f_tag_val, 22'h2A);
    chk("gap.done_cnt", f_done_cnt, 1);
    chk("gap.done_cyc", f_done_cyc, 15);
    chk("gap.tag_cyc",  f_tag_cyc, 14);
    chk("gap.no_refill0", f_post_req[0], 0);
    chk("gap.no_refill1", f_post_req[1], 0);

    // Word order for 0x1238 plus refill: stall held through mem_done.
    do_reset();
    run_fill(A1238, 0, 0, 1'b1, 40);
    chk("cwf.addr",     f_addr, M1238);
    check_beats("cwf", S1238);
    chk("cwf.tag_val",  f_tag_val, 22'h4);
    chk("cwf.tag_idx",  f_tag_idx, 6'h23);
    chk("cwf.done_cyc", f_done_cyc, 7);
    chk("cwf.tag_cyc",  f_tag_cyc, 6);
    chk("refill.idle_cycle", f_post_req[0], 0);
    chk("refill.req",        f_post_req[1], 1);

    // Reset after the 2nd beat; remaining beats must be ignored.
    do_reset();
    begin
      int we_cnt = 0;
      int tag_cnt = 0;
      int done_cnt = 0;
      @(posedge clk); #1;
      bus.read_state = READ_STALL; bus.miss_addr = A1234;
      @(posedge clk); #1;
      bus.read_state = READ_IDLE; bus.mem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = BEAT_BASE;
      @(negedge clk);
      chk("rstmid.beat0_we", bus.fill_we, 1);
      @(posedge clk); #1;
      bus.mem_rdata = BEAT_BASE + 32'd1;
      @(negedge clk);
      chk("rstmid.beat1_we", bus.fill_we, 1);
      @(posedge clk); #1;
      rst = 1'b1; bus.mem_rdata = BEAT_BASE + 32'd2;
      @(posedge clk); #1;
      rst = 1'b0; bus.mem_rdata = BEAT_BASE + 32'd3;
      @(negedge clk);
      check_zero("rstmid");
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        bus.mem_rvalid = (c % 2 == 0);
        bus.mem_rdata  = BEAT_BASE + 32'(4 + c);
        @(negedge clk);
        if (bus.fill_we)  we_cnt++;
        if (bus.tag_we)   tag_cnt++;
        if (bus.mem_done) done_cnt++;
      end
      chk("rstmid.we_after",   we_cnt, 0);
      chk("rstmid.tag_after",  tag_cnt, 0);
      chk("rstmid.done_after", done_cnt, 0);
      idle_inputs();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
